// File: rtl/plc_timer_pkg.sv
// -----------------------------------------------------------------------------
// plc_timer_pkg
// Shared definitions for the PLC timer bank: the per-channel mode encodings
// and the default accumulator/preset width.
// -----------------------------------------------------------------------------
package plc_timer_pkg;

  // Two-bit per-channel timer mode as carried on the packed mode bus.
  typedef enum logic [1:0] {
    MODE_TON  = 2'b00,  // on-delay
    MODE_TOF  = 2'b01,  // off-delay
    MODE_RTO  = 2'b10,  // retentive on-delay
    MODE_RSVD = 2'b11   // reserved: channel held permanently disabled
  } timer_mode_e;

  // Default accumulator/preset width in bits (milliseconds).
  localparam int unsigned DEFAULT_CNT_W = 32;

endpackage : plc_timer_pkg

// File: rtl/plc_timer_channel.sv
// -----------------------------------------------------------------------------
// plc_timer_channel
// One ladder-logic timer channel: TON, TOF or RTO selected at run time.
// The accumulator advances one count per tick_pulse, saturating at preset.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   tick_pulse one-clk-wide 1 ms strobe shared by every channel
//   mode       channel mode (timer_mode_e encoding)
//   enabled    rung input
//   clr        synchronous accumulator clear (all modes)
//   preset     terminal count in ms
//   done       registered done bit
//   timing     registered "counting in progress"
//   accum      registered elapsed ms
// -----------------------------------------------------------------------------
module plc_timer_channel
  import plc_timer_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_pulse,
  input  logic [1:0]       mode,
  input  logic             enabled,
  input  logic             clr,
  input  logic [CNT_W-1:0] preset,
  output logic             done,
  output logic             timing,
  output logic [CNT_W-1:0] accum
);

  logic [1:0]       mode_q;
  logic [CNT_W-1:0] acc_q;
  logic             done_q;
  logic             timing_q;

  logic [CNT_W-1:0] acc_cnt;
  logic [CNT_W-1:0] acc_n;
  logic             done_n;
  logic             timing_n;

  // Next-state logic. acc_n is resolved first inside each branch so that
  // done and timing are derived from the post-tick accumulator, giving zero
  // extra latency after the terminal tick.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    acc_n    = acc_q;
    done_n   = done_q;
    timing_n = 1'b0;

    // Saturating increment: never passes preset, never wraps. If preset is
    // lowered below acc the accumulator simply holds.
    acc_cnt  = (tick_pulse && (acc_q < preset)) ? acc_q + CNT_W'(1) : acc_q;

    if ((mode != mode_q) || clr) begin
      // Mode change outranks clr; both zero the channel for one cycle.
      acc_n  = '0;
      done_n = 1'b0;
    end else begin
      case (mode)
        MODE_TON: begin
          if (enabled) begin
            acc_n    = acc_cnt;
            done_n   = (acc_n >= preset);
            timing_n = (acc_n < preset);
          end else begin
            acc_n  = '0;
            done_n = 1'b0;
          end
        end

        MODE_TOF: begin
          if (enabled) begin
            // Rung true re-arms the off-delay.
            acc_n  = '0;
            done_n = 1'b1;
          end else if (done_q) begin
            acc_n    = acc_cnt;
            done_n   = (acc_n < preset);
            timing_n = done_n;
          end
          // enabled low with done low: idle, acc held by the defaults.
        end

        MODE_RTO: begin
          if (enabled) begin
            acc_n = acc_cnt;
          end
          done_n   = (acc_n >= preset);
          timing_n = enabled && (acc_n < preset);
        end

        default: begin
          acc_n  = '0;
          done_n = 1'b0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q   <= MODE_TON;
      acc_q    <= '0;
      done_q   <= 1'b0;
      timing_q <= 1'b0;
    end else begin
      mode_q   <= mode;
      acc_q    <= acc_n;
      done_q   <= done_n;
      timing_q <= timing_n;
    end
  end

  assign done   = done_q;
  assign timing = timing_q;
  assign accum  = acc_q;

endmodule : plc_timer_channel

// File: rtl/plc_timer_bank.sv
// -----------------------------------------------------------------------------
// plc_timer_bank
// Bank of N_CH independent PLC timers sharing one 1 kHz tick. The top level
// only detects the tick rising edge and packs/unpacks the per-channel buses.
//
// Ports:
//   clk      system clock
//   rst      asynchronous active-low reset
//   tick     1 kHz tick, synchronous to clk (rising edge = 1 ms)
//   mode     per-channel mode, channel i at [2i+1:2i]
//   enabled  per-channel rung input
//   clr      per-channel synchronous accumulator clear
//   preset   per-channel preset (ms), channel i at [CNT_W*i +: CNT_W]
//   done     per-channel done, registered
//   timing   per-channel counting-in-progress, registered
//   accum    per-channel elapsed ms, registered, packed as preset
// -----------------------------------------------------------------------------
module plc_timer_bank
  import plc_timer_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic [2*N_CH-1:0]     mode,
  input  logic [N_CH-1:0]       enabled,
  input  logic [N_CH-1:0]       clr,
  input  logic [N_CH*CNT_W-1:0] preset,
  output logic [N_CH-1:0]       done,
  output logic [N_CH-1:0]       timing,
  output logic [N_CH*CNT_W-1:0] accum
);

  logic tick_q;
  logic tick_pulse;

  // tick_q resets low, so a tick already high at reset release counts on
  // the first clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= tick;
    end
  end

  assign tick_pulse = tick & ~tick_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    plc_timer_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .tick_pulse (tick_pulse),
      .mode       (mode[2*i +: 2]),
      .enabled    (enabled[i]),
      .clr        (clr[i]),
      .preset     (preset[CNT_W*i +: CNT_W]),
      .done       (done[i]),
      .timing     (timing[i]),
      .accum      (accum[CNT_W*i +: CNT_W])
    );
  end

endmodule : plc_timer_bank

// File: tb/tb_plc_timer_bank.sv
// -----------------------------------------------------------------------------
// tb_plc_timer_bank
// Directed self-checking bench for plc_timer_bank: a 4-channel, 32-bit bank
// plus a 1-channel, 8-bit bank for the saturation case. Inputs change on the
// falling clock edge; outputs are examined on the following falling edge.
// -----------------------------------------------------------------------------
module tb_plc_timer_bank;
  import plc_timer_pkg::*;

  localparam int N_CH  = 4;
  localparam int CNT_W = 32;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  tick;
  logic [2*N_CH-1:0]     mode;
  logic [N_CH-1:0]       enabled;
  logic [N_CH-1:0]       clr;
  logic [N_CH*CNT_W-1:0] preset;
  logic [N_CH-1:0]       done;
  logic [N_CH-1:0]       timing;
  logic [N_CH*CNT_W-1:0] accum;

  logic [1:0] mode8;
  logic       en8;
  logic       clr8;
  logic [7:0] preset8;
  logic       done8;
  logic       timing8;
  logic [7:0] accum8;

  int n_checks = 0;
  int n_fail   = 0;

  plc_timer_bank #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .mode    (mode),
    .enabled (enabled),
    .clr     (clr),
    .preset  (preset),
    .done    (done),
    .timing  (timing),
    .accum   (accum)
  );

  plc_timer_bank #(.N_CH(1), .CNT_W(8)) dut8 (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .mode    (mode8),
    .enabled (en8),
    .clr     (clr8),
    .preset  (preset8),
    .done    (done8),
    .timing  (timing8),
    .accum   (accum8)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------- helpers
  function automatic logic [CNT_W-1:0] acc_of(input int ch);
    return accum[CNT_W*ch +: CNT_W];
  endfunction

  task automatic set_mode(input int ch, input timer_mode_e m);
    mode[2*ch +: 2] = m;
  endtask

  task automatic set_preset(input int ch, input logic [CNT_W-1:0] v);
    preset[CNT_W*ch +: CNT_W] = v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One tick rising edge seen by exactly one posedge; returns on the falling
  // edge right after that posedge, when the counted result is visible.
  task automatic pulse_tick();
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk) rst = 1'b0;
    idle(2);
    rst = 1'b1;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    idle(2);
    n_checks++;
    if (done !== '0 || timing !== '0 || accum !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: done=%b timing=%b accum=%h, expected all zero", done, timing, accum);
    end
    n_checks++;
    if (done8 !== 1'b0 || timing8 !== 1'b0 || accum8 !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_hold8: done=%b timing=%b accum=%0d, expected all zero", done8, timing8, accum8);
    end
    rst = 1'b1;
    idle(1);
    n_checks++;
    if (done !== '0 || timing !== '0 || accum !== '0) begin
      n_fail++;
      $display("FAIL reset_release: done=%b timing=%b accum=%h, expected all zero", done, timing, accum);
    end
  endtask

  task automatic test_ton();
    set_preset(0, 5);
    set_mode(0, MODE_TON);
    enabled[0] = 1'b1;
    idle(1);
    for (int k = 1; k <= 6; k++) begin
      int exp_acc;
      logic exp_done, exp_tim;
      idle(8);
      pulse_tick();
      exp_acc  = (k > 5) ? 5 : k;
      exp_done = (k >= 5);
      exp_tim  = (k < 5);
      n_checks++;
      if (acc_of(0) !== exp_acc || done[0] !== exp_done || timing[0] !== exp_tim) begin
        n_fail++;
        $display("FAIL ton_tick%0d: accum=%0d done=%b timing=%b, expected accum=%0d done=%b timing=%b",
                 k, acc_of(0), done[0], timing[0], exp_acc, exp_done, exp_tim);
      end
    end
  endtask

  task automatic test_ton_restart();
    enabled[0] = 1'b0;
    idle(1);
    enabled[0] = 1'b1;
    repeat (3) pulse_tick();
    n_checks++;
    if (acc_of(0) !== 3 || done[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL ton_restart_pre: accum=%0d done=%b, expected accum=3 done=0", acc_of(0), done[0]);
    end
    enabled[0] = 1'b0;
    idle(1);
    n_checks++;
    if (acc_of(0) !== 0 || done[0] !== 1'b0 || timing[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL ton_restart_drop: accum=%0d done=%b timing=%b, expected 0 0 0", acc_of(0), done[0], timing[0]);
    end
    enabled[0] = 1'b1;
    repeat (4) pulse_tick();
    n_checks++;
    if (acc_of(0) !== 4 || done[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL ton_restart_4: accum=%0d done=%b, expected accum=4 done=0", acc_of(0), done[0]);
    end
    pulse_tick();
    n_checks++;
    if (acc_of(0) !== 5 || done[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL ton_restart_5: accum=%0d done=%b, expected accum=5 done=1", acc_of(0), done[0]);
    end
  endtask

  task automatic test_tof();
    set_mode(1, MODE_TOF);
    set_preset(1, 3);
    idle(1);
    enabled[1] = 1'b1;
    idle(1);
    n_checks++;
    if (done[1] !== 1'b1 || acc_of(1) !== 0 || timing[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL tof_arm: done=%b accum=%0d timing=%b, expected 1 0 0", done[1], acc_of(1), timing[1]);
    end
    enabled[1] = 1'b0;
    idle(1);
    n_checks++;
    if (done[1] !== 1'b1 || timing[1] !== 1'b1 || acc_of(1) !== 0) begin
      n_fail++;
      $display("FAIL tof_fall: done=%b timing=%b accum=%0d, expected 1 1 0", done[1], timing[1], acc_of(1));
    end
    for (int k = 1; k <= 3; k++) begin
      logic exp_done;
      idle(3);
      pulse_tick();
      exp_done = (k < 3);
      n_checks++;
      if (acc_of(1) !== k || done[1] !== exp_done || timing[1] !== exp_done) begin
        n_fail++;
        $display("FAIL tof_tick%0d: accum=%0d done=%b timing=%b, expected accum=%0d done=%b timing=%b",
                 k, acc_of(1), done[1], timing[1], k, exp_done, exp_done);
      end
    end
    // Re-raise mid-delay.
    enabled[1] = 1'b1;
    idle(1);
    enabled[1] = 1'b0;
    pulse_tick();
    enabled[1] = 1'b1;
    idle(1);
    n_checks++;
    if (acc_of(1) !== 0 || done[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL tof_rearm: accum=%0d done=%b, expected accum=0 done=1", acc_of(1), done[1]);
    end
  endtask

  task automatic test_rto();
    set_mode(2, MODE_RTO);
    set_preset(2, 4);
    idle(1);
    enabled[2] = 1'b1;
    repeat (2) pulse_tick();
    n_checks++;
    if (acc_of(2) !== 2 || done[2] !== 1'b0 || timing[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL rto_run2: accum=%0d done=%b timing=%b, expected 2 0 1", acc_of(2), done[2], timing[2]);
    end
    enabled[2] = 1'b0;
    repeat (10) pulse_tick();
    n_checks++;
    if (acc_of(2) !== 2 || done[2] !== 1'b0 || timing[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL rto_hold: accum=%0d done=%b timing=%b, expected 2 0 0", acc_of(2), done[2], timing[2]);
    end
    enabled[2] = 1'b1;
    repeat (2) pulse_tick();
    enabled[2] = 1'b0;
    idle(1);
    n_checks++;
    if (acc_of(2) !== 4 || done[2] !== 1'b1 || timing[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL rto_done: accum=%0d done=%b timing=%b, expected 4 1 0", acc_of(2), done[2], timing[2]);
    end
    clr[2] = 1'b1;
    idle(1);
    clr[2] = 1'b0;
    n_checks++;
    if (acc_of(2) !== 0 || done[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL rto_clr: accum=%0d done=%b, expected accum=0 done=0", acc_of(2), done[2]);
    end
    // clr coinciding with a tick edge: clr wins and the tick is lost.
    enabled[2] = 1'b1;
    clr[2]     = 1'b1;
    tick       = 1'b1;
    idle(1);
    clr[2] = 1'b0;
    tick   = 1'b0;
    idle(2);
    n_checks++;
    if (acc_of(2) !== 0 || timing[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL rto_clr_tick: accum=%0d timing=%b, expected accum=0 timing=1", acc_of(2), timing[2]);
    end
  endtask

  task automatic test_multi_channel();
    // Expected per tick, channels 0..3 = TON p2, TOF p3, RTO p4, reserved.
    int   exp_acc  [4][4] = '{'{1, 1, 1, 0}, '{2, 2, 2, 0}, '{2, 3, 3, 0}, '{2, 3, 4, 0}};
    logic exp_done [4][4] = '{'{0, 1, 0, 0}, '{1, 1, 0, 0}, '{1, 0, 0, 0}, '{1, 0, 1, 0}};
    enabled = '0;
    clr     = '0;
    apply_reset();
    set_mode(0, MODE_TON);  set_preset(0, 2);
    set_mode(1, MODE_TOF);  set_preset(1, 3);
    set_mode(2, MODE_RTO);  set_preset(2, 4);
    set_mode(3, MODE_RSVD); set_preset(3, 1);
    idle(1);
    n_checks++;
    if (done !== '0 || timing !== '0 || accum !== '0) begin
      n_fail++;
      $display("FAIL multi_modeset: done=%b timing=%b accum=%h, expected all zero", done, timing, accum);
    end
    n_checks++;
    if (done[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL multi_tof_idle: done=%b, expected 0", done[1]);
    end
    enabled = 4'b1111;
    idle(1);
    enabled = 4'b1101;
    idle(1);
    for (int t = 0; t < 4; t++) begin
      pulse_tick();
      for (int c = 0; c < 4; c++) begin
        n_checks++;
        if (acc_of(c) !== exp_acc[t][c] || done[c] !== exp_done[t][c]) begin
          n_fail++;
          $display("FAIL multi_t%0d_ch%0d: accum=%0d done=%b, expected accum=%0d done=%b",
                   t + 1, c, acc_of(c), done[c], exp_acc[t][c], exp_done[t][c]);
        end
      end
    end
    n_checks++;
    if (timing[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL multi_rsvd_timing: timing=%b, expected 0", timing[3]);
    end
  endtask

  task automatic test_preset_zero();
    set_preset(0, 0);
    enabled[0] = 1'b0;
    idle(1);
    n_checks++;
    if (done[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL pz_off: done=%b, expected 0", done[0]);
    end
    enabled[0] = 1'b1;
    idle(1);
    n_checks++;
    if (done[0] !== 1'b1 || acc_of(0) !== 0 || timing[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL pz_on: done=%b accum=%0d timing=%b, expected 1 0 0", done[0], acc_of(0), timing[0]);
    end
  endtask

  task automatic test_mode_switch();
    set_preset(2, 10);
    pulse_tick();
    n_checks++;
    if (acc_of(2) !== 5 || timing[2] !== 1'b1 || done[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL msw_pre: accum=%0d timing=%b done=%b, expected 5 1 0", acc_of(2), timing[2], done[2]);
    end
    set_mode(2, MODE_TON);
    idle(1);
    n_checks++;
    if (acc_of(2) !== 0 || timing[2] !== 1'b0 || done[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL msw_switch: accum=%0d timing=%b done=%b, expected 0 0 0", acc_of(2), timing[2], done[2]);
    end
  endtask

  task automatic test_reset_mid();
    set_preset(0, 10);
    enabled[0] = 1'b0;
    idle(1);
    enabled[0] = 1'b1;
    repeat (3) pulse_tick();
    n_checks++;
    if (acc_of(0) !== 3) begin
      n_fail++;
      $display("FAIL rmid_pre: accum=%0d, expected 3", acc_of(0));
    end
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (done !== '0 || timing !== '0 || accum !== '0) begin
      n_fail++;
      $display("FAIL rmid_async: done=%b timing=%b accum=%h, expected all zero", done, timing, accum);
    end
    @(negedge clk) rst = 1'b1;
  endtask

  task automatic test_sat8();
    mode8   = MODE_TON;
    preset8 = 8'd255;
    en8     = 1'b1;
    idle(1);
    repeat (254) pulse_tick();
    n_checks++;
    if (accum8 !== 8'd254 || done8 !== 1'b0 || timing8 !== 1'b1) begin
      n_fail++;
      $display("FAIL sat8_254: accum=%0d done=%b timing=%b, expected 254 0 1", accum8, done8, timing8);
    end
    pulse_tick();
    n_checks++;
    if (accum8 !== 8'd255 || done8 !== 1'b1 || timing8 !== 1'b0) begin
      n_fail++;
      $display("FAIL sat8_255: accum=%0d done=%b timing=%b, expected 255 1 0", accum8, done8, timing8);
    end
    repeat (2) pulse_tick();
    n_checks++;
    if (accum8 !== 8'd255 || done8 !== 1'b1) begin
      n_fail++;
      $display("FAIL sat8_nowrap: accum=%0d done=%b, expected 255 1", accum8, done8);
    end
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    rst     = 1'b0;
    tick    = 1'b0;
    mode    = '0;
    enabled = '0;
    clr     = '0;
    preset  = '0;
    mode8   = 2'b00;
    en8     = 1'b0;
    clr8    = 1'b0;
    preset8 = 8'd0;

    test_reset();
    test_ton();
    test_ton_restart();
    test_tof();
    test_rto();
    test_multi_channel();
    test_preset_zero();
    test_mode_switch();
    test_reset_mid();
    test_sat8();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_plc_timer_bank

// File: doc/plc_timer_bank.md
# plc_timer_bank

Parametrised bank of N_CH independent ladder-logic timers sharing one 1 kHz tick, each selectable at run time as on-delay (TON), off-delay (TOF) or retentive (RTO). It replaces single-channel on-delay timers in the generated ladder fabric. It adds a per-channel accumulator readback, a timing-in-progress flag, an explicit accumulator clear, and a held `done`.

## Interface
- N_CH, 4, number of timer channels (1..32)
- CNT_W, 32, accumulator/preset width in bits (8..32)

- clk  in  1  system clock; one clock domain
- rst  in  1  asynchronous active-low reset
- tick  in  1  1 kHz down-sampled clock, synchronous to clk; each rising edge = 1 ms
- mode  in  2*N_CH  per-channel mode, channel i at [2i+1:2i]: 00 TON, 01 TOF, 10 RTO, 11 reserved
- enabled  in  N_CH  per-channel rung input
- clr  in  N_CH  per-channel synchronous accumulator clear (RTO reset rung; honoured in all modes)
- preset  in  N_CH*CNT_W  per-channel preset in ms, channel i at [CNT_W*i +: CNT_W]
- done  out  N_CH  per-channel done bit, registered
- timing  out  N_CH  per-channel "counting in progress", registered
- accum  out  N_CH*CNT_W  per-channel elapsed ms, registered, same packing as preset

## Operation
- The shared edge detector registers tick_q and forms tick_pulse = tick & ~tick_q. tick_pulse is one clk wide and feeds all channels.
- Accumulator rule, all modes: on tick_pulse, while counting is permitted, acc increments only if acc < preset. It saturates at preset and never wraps. If preset is lowered below acc, acc holds and done follows the compare.
- Priority per channel, highest first: reset, mode change, clr, mode rule.
- Mode change: when mode differs from its registered copy mode_q, acc, done and timing clear to 0 for that cycle and mode_q updates.
- clr: acc = 0, done = 0, timing = 0 for that cycle. Normal rules resume on the next cycle.
- TON:
  - enabled = 0: acc = 0, done = 0.
  - enabled = 1: count, and done = (acc_next >= preset).
  - timing = enabled & (acc_next < preset).
- TOF:
  - enabled = 1: acc = 0, done = 1.
  - enabled = 0 and done = 1: count, and done clears when acc_next >= preset. acc then holds.
  - enabled = 0 and done = 0: idle, with acc held.
  - timing = ~enabled & done_next.
- RTO:
  - enabled = 1: count.
  - enabled = 0: acc holds.
  - done = (acc_next >= preset), held until clr.
  - timing = enabled & (acc_next < preset).
- Mode 11 behaves as permanently disabled: acc = 0, done = 0, timing = 0.
- Channels are fully independent. Simultaneous events across channels need no arbitration.

## Timing
- Reset (rst = 0, async): tick_q = 0, all acc = 0, done = 0, timing = 0, mode_q = 00.
  - After reset a TOF channel stays idle (done = 0) until enabled is first seen high.
  - If tick is high when reset releases, the first clk sees a rising edge and counts.
- Count latency: acc updates on the same clk edge at which tick is first sampled high. done and timing update on that same edge (computed from acc_next), so there are zero extra cycles after the terminal tick.
- preset = 0:
  - TON/RTO: done rises one clk after enabled is sampled high, with no tick needed.
  - TOF: done falls one clk after enabled is sampled low.
- enabled toggling between ticks: TON restarts from 0, RTO retains, TOF re-arms to done = 1.
- clr and tick_pulse in the same cycle: clr wins, and that tick is lost.
- Reset asserted mid-count aborts immediately. There is no recovery of acc.

## Structure
- Package plc_timer_pkg holds:
  - the mode encodings as constants/enum (MODE_TON, MODE_TOF, MODE_RTO, MODE_RSVD)
  - the default CNT_W
- Sub-module plc_timer_channel holds one channel's acc/done/timing/mode_q logic. It takes tick_pulse, is parametrised by CNT_W, and is instantiated N_CH times in a generate loop.
- The top level holds only the tick edge detector and the port packing.

## Test plan
- TON, preset = 5, enabled held high, tick rising every 10 clk -> done rises on the clk of the 5th tick edge; accum stops at 5; timing high from the 1st through 4th edge, then 0; done holds while enabled stays high.
- TON, preset = 5, enabled dropped after 3 ticks then raised -> accum 0 on the next clk, done stays 0, and the count restarts from 0 (done after 5 more ticks).
- TOF, preset = 3, enabled 1→0 -> done stays 1 for 3 tick edges, falls on the 3rd; re-raising enabled mid-delay gives accum = 0, done = 1 next clk.
- RTO, preset = 4: enabled high for 2 ticks, low for 10, high for 2 -> accum 2, held at 2, then 4 with done = 1 held after enabled falls; clr pulse -> accum 0, done 0 next clk.
- Four channels in TON/TOF/RTO/11 with different presets, all sharing one tick stream -> each matches its model independently; the mode-11 channel stays at 0.
- Edge cases:
  - preset = 0 in TON -> done one clk after enabled rises.
  - mode switched mid-count -> all channel outputs 0 next clk.
  - rst pulsed low mid-count -> all outputs 0 asynchronously.
  - CNT_W = 8, preset = 255 -> saturates at 255, no wrap.
